// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - fully-associative software-managed TLB translating I/D virtual addresses to cache fields
module mmu_tlb #(
  parameter int TLB_ENTRIES = 8,
  parameter int INDEX_W     = 8,
  parameter int OFFSET_W    = 4,
  parameter int K0_CACHED   = 1,
  localparam int IW = $clog2(TLB_ENTRIES),
  localparam int TW = 32 - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          asid,
  input  logic                inst_req,
  input  logic [31:0]         inst_vaddr,
  output logic                inst_valid,
  output logic [TW-1:0]       inst_tag,
  output logic [INDEX_W-1:0]  inst_index,
  output logic [OFFSET_W-1:0] inst_offset,
  output logic                inst_cache,
  output logic                inst_refill,
  output logic                inst_invalid,
  input  logic                data_req,
  input  logic [31:0]         data_vaddr,
  input  logic                data_wr,
  output logic                data_valid,
  output logic [TW-1:0]       data_tag,
  output logic [INDEX_W-1:0]  data_index,
  output logic [OFFSET_W-1:0] data_offset,
  output logic                data_cache,
  output logic                data_refill,
  output logic                data_invalid,
  output logic                data_mod,
  input  logic                tlbw_en,
  input  logic [IW-1:0]       tlbw_idx,
  input  logic [18:0]         tlbw_vpn2,
  input  logic [7:0]          tlbw_asid,
  input  logic                tlbw_g,
  input  logic [24:0]         tlbw_lo0,
  input  logic [24:0]         tlbw_lo1,
  input  logic                tlbp_req,
  input  logic [18:0]         tlbp_vpn2,
  output logic                tlbp_done,
  output logic                tlbp_hit,
  output logic [IW-1:0]       tlbp_idx
);

  localparam int FW = INDEX_W + OFFSET_W;

  logic        e_q    [TLB_ENTRIES], e_d    [TLB_ENTRIES];
  logic [18:0] vpn2_q [TLB_ENTRIES], vpn2_d [TLB_ENTRIES];
  logic [7:0]  asid_q [TLB_ENTRIES], asid_d [TLB_ENTRIES];
  logic        g_q    [TLB_ENTRIES], g_d    [TLB_ENTRIES];
  logic [24:0] lo0_q  [TLB_ENTRIES], lo0_d  [TLB_ENTRIES];
  logic [24:0] lo1_q  [TLB_ENTRIES], lo1_d  [TLB_ENTRIES];

  // Result word: {refill, invalid, mod, cache, pa[31:0]}. Descending scan lets the lowest matching index win.
  function automatic logic [35:0] xlate(input logic [31:0] va, input logic [7:0] as, input logic wr);
    logic        hit;
    logic [24:0] lo;
    hit = 1'b0;
    lo  = '0;
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
      return {3'b000, (va[31:29] == 3'b100) && (K0_CACHED != 0), 3'b000, va[28:0]};
    end
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (e_q[i] && vpn2_q[i] == va[31:13] && (g_q[i] || asid_q[i] == as)) begin
        hit = 1'b1;
        lo  = va[12] ? lo1_q[i] : lo0_q[i];
      end
    end
    if (!hit)             return {1'b1, 35'd0};
    else if (!lo[0])      return {2'b01, 34'd0};
    else if (wr && !lo[1]) return {3'b001, 33'd0};
    else                  return {3'b000, lo[4:2] == 3'd3, lo[24:5], va[11:0]};
  endfunction

  // Entry update: the written entry becomes visible from the cycle after tlbw_en.
  always_comb begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      e_d[i]    = e_q[i];
      vpn2_d[i] = vpn2_q[i];
      asid_d[i] = asid_q[i];
      g_d[i]    = g_q[i];
      lo0_d[i]  = lo0_q[i];
      lo1_d[i]  = lo1_q[i];
    end
    if (tlbw_en) begin
      e_d[tlbw_idx]    = 1'b1;
      vpn2_d[tlbw_idx] = tlbw_vpn2;
      asid_d[tlbw_idx] = tlbw_asid;
      g_d[tlbw_idx]    = tlbw_g;
      lo0_d[tlbw_idx]  = tlbw_lo0;
      lo1_d[tlbw_idx]  = tlbw_lo1;
    end
  end

  // Entry storage, fully cleared on reset so no entry matches until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (rst) begin
        e_q[i] <= 1'b0; vpn2_q[i] <= '0; asid_q[i] <= '0;
        g_q[i] <= 1'b0; lo0_q[i]  <= '0; lo1_q[i]  <= '0;
      end else begin
        e_q[i] <= e_d[i]; vpn2_q[i] <= vpn2_d[i]; asid_q[i] <= asid_d[i];
        g_q[i] <= g_d[i]; lo0_q[i]  <= lo0_d[i];  lo1_q[i]  <= lo1_d[i];
      end
    end
  end

  logic [35:0]         ires, dres;
  logic                iok, dok;
  logic                inst_valid_q, inst_valid_d, inst_cache_q, inst_cache_d;
  logic                inst_refill_q, inst_refill_d, inst_invalid_q, inst_invalid_d;
  logic [TW-1:0]       inst_tag_q, inst_tag_d, data_tag_q, data_tag_d;
  logic [INDEX_W-1:0]  inst_index_q, inst_index_d, data_index_q, data_index_d;
  logic [OFFSET_W-1:0] inst_offset_q, inst_offset_d, data_offset_q, data_offset_d;
  logic                data_valid_q, data_valid_d, data_cache_q, data_cache_d;
  logic                data_refill_q, data_refill_d, data_invalid_q, data_invalid_d;
  logic                data_mod_q, data_mod_d;
  logic                tlbp_done_q, tlbp_done_d, tlbp_hit_q, tlbp_hit_d;
  logic [IW-1:0]       tlbp_idx_q, tlbp_idx_d;
  logic                p_hit;
  logic [IW-1:0]       p_idx;

  // Next-state for both lookup ports; fields are zero whenever there is no request or an exception.
  always_comb begin
    ires = xlate(inst_vaddr, asid, 1'b0);
    dres = xlate(data_vaddr, asid, data_wr);
    iok  = inst_req && (ires[35:33] == 3'b000);
    dok  = data_req && (dres[35:33] == 3'b000);
    inst_valid_d   = inst_req;
    inst_refill_d  = inst_req && ires[35];
    inst_invalid_d = inst_req && ires[34];
    inst_cache_d   = iok && ires[32];
    inst_tag_d     = iok ? ires[31:FW] : '0;
    inst_index_d   = iok ? ires[FW-1:OFFSET_W] : '0;
    inst_offset_d  = iok ? ires[OFFSET_W-1:0] : '0;
    data_valid_d   = data_req;
    data_refill_d  = data_req && dres[35];
    data_invalid_d = data_req && dres[34];
    data_mod_d     = data_req && dres[33];
    data_cache_d   = dok && dres[32];
    data_tag_d     = dok ? dres[31:FW] : '0;
    data_index_d   = dok ? dres[FW-1:OFFSET_W] : '0;
    data_offset_d  = dok ? dres[OFFSET_W-1:0] : '0;
  end

  // Probe compare; hit/idx hold between probes and idx reads 0 on a miss.
  always_comb begin
    p_hit = 1'b0;
    p_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (e_q[i] && vpn2_q[i] == tlbp_vpn2 && (g_q[i] || asid_q[i] == asid)) begin
        p_hit = 1'b1;
        p_idx = i[IW-1:0];
      end
    end
    tlbp_done_d = tlbp_req;
    tlbp_hit_d  = tlbp_req ? p_hit : tlbp_hit_q;
    tlbp_idx_d  = tlbp_req ? p_idx : tlbp_idx_q;
  end

  // Output registers; reset drops any request presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid_q <= 1'b0; inst_cache_q <= 1'b0; inst_refill_q <= 1'b0; inst_invalid_q <= 1'b0;
      inst_tag_q <= '0; inst_index_q <= '0; inst_offset_q <= '0;
      data_valid_q <= 1'b0; data_cache_q <= 1'b0; data_refill_q <= 1'b0; data_invalid_q <= 1'b0;
      data_mod_q <= 1'b0; data_tag_q <= '0; data_index_q <= '0; data_offset_q <= '0;
      tlbp_done_q <= 1'b0; tlbp_hit_q <= 1'b0; tlbp_idx_q <= '0;
    end else begin
      inst_valid_q <= inst_valid_d; inst_cache_q <= inst_cache_d;
      inst_refill_q <= inst_refill_d; inst_invalid_q <= inst_invalid_d;
      inst_tag_q <= inst_tag_d; inst_index_q <= inst_index_d; inst_offset_q <= inst_offset_d;
      data_valid_q <= data_valid_d; data_cache_q <= data_cache_d;
      data_refill_q <= data_refill_d; data_invalid_q <= data_invalid_d; data_mod_q <= data_mod_d;
      data_tag_q <= data_tag_d; data_index_q <= data_index_d; data_offset_q <= data_offset_d;
      tlbp_done_q <= tlbp_done_d; tlbp_hit_q <= tlbp_hit_d; tlbp_idx_q <= tlbp_idx_d;
    end
  end

  assign inst_valid = inst_valid_q;     assign inst_cache = inst_cache_q;
  assign inst_refill = inst_refill_q;   assign inst_invalid = inst_invalid_q;
  assign inst_tag = inst_tag_q;         assign inst_index = inst_index_q;
  assign inst_offset = inst_offset_q;
  assign data_valid = data_valid_q;     assign data_cache = data_cache_q;
  assign data_refill = data_refill_q;   assign data_invalid = data_invalid_q;
  assign data_mod = data_mod_q;         assign data_tag = data_tag_q;
  assign data_index = data_index_q;     assign data_offset = data_offset_q;
  assign tlbp_done = tlbp_done_q;       assign tlbp_hit = tlbp_hit_q;
  assign tlbp_idx = tlbp_idx_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - directed self-checking bench for mmu_tlb
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  asid = '0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_vaddr = '0;
  logic        inst_valid, inst_cache, inst_refill, inst_invalid;
  logic [19:0] inst_tag;
  logic [7:0]  inst_index;
  logic [3:0]  inst_offset;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [31:0] data_vaddr = '0;
  logic        data_valid, data_cache, data_refill, data_invalid, data_mod;
  logic [19:0] data_tag;
  logic [7:0]  data_index;
  logic [3:0]  data_offset;
  logic        tlbw_en = 1'b0, tlbw_g = 1'b0;
  logic [2:0]  tlbw_idx = '0;
  logic [18:0] tlbw_vpn2 = '0;
  logic [7:0]  tlbw_asid = '0;
  logic [24:0] tlbw_lo0 = '0, tlbw_lo1 = '0;
  logic        tlbp_req = 1'b0;
  logic [18:0] tlbp_vpn2 = '0;
  logic        tlbp_done, tlbp_hit;
  logic [2:0]  tlbp_idx;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [24:0] LO_A    = {20'h12345, 3'd3, 1'b1, 1'b1};
  localparam logic [24:0] LO_A_ND = {20'h12345, 3'd3, 1'b0, 1'b1};
  localparam logic [24:0] LO_INV  = {20'h54321, 3'd3, 1'b1, 1'b0};

  mmu_tlb dut (
    .clk(clk), .rst(rst), .asid(asid),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_valid(inst_valid),
    .inst_tag(inst_tag), .inst_index(inst_index), .inst_offset(inst_offset),
    .inst_cache(inst_cache), .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .data_req(data_req), .data_vaddr(data_vaddr), .data_wr(data_wr), .data_valid(data_valid),
    .data_tag(data_tag), .data_index(data_index), .data_offset(data_offset),
    .data_cache(data_cache), .data_refill(data_refill), .data_invalid(data_invalid),
    .data_mod(data_mod),
    .tlbw_en(tlbw_en), .tlbw_idx(tlbw_idx), .tlbw_vpn2(tlbw_vpn2), .tlbw_asid(tlbw_asid),
    .tlbw_g(tlbw_g), .tlbw_lo0(tlbw_lo0), .tlbw_lo1(tlbw_lo1),
    .tlbp_req(tlbp_req), .tlbp_vpn2(tlbp_vpn2), .tlbp_done(tlbp_done),
    .tlbp_hit(tlbp_hit), .tlbp_idx(tlbp_idx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tlbw(input logic [2:0] idx, input logic [18:0] vpn, input logic [7:0] a,
                      input logic g, input logic [24:0] l0, input logic [24:0] l1);
    tlbw_en = 1'b1; tlbw_idx = idx; tlbw_vpn2 = vpn; tlbw_asid = a;
    tlbw_g = g; tlbw_lo0 = l0; tlbw_lo1 = l1;
    cyc();
    tlbw_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got %0b want 0", data_valid); end
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== 5'd0) begin n_err++; $display("FAIL reset_probe got %b want 00000", {tlbp_done, tlbp_hit, tlbp_idx}); end
    n_cmp++; if ({inst_tag, inst_index, inst_offset, data_refill, data_mod} !== 34'd0) begin n_err++; $display("FAIL reset_fields got %h want 0", {inst_tag, inst_index, inst_offset, data_refill, data_mod}); end
    rst = 1'b0;
  endtask

  task automatic test_unmapped();
    inst_req = 1'b1; inst_vaddr = 32'h9FC0_1234;
    cyc();
    inst_vaddr = 32'hBFC0_0000;
    n_cmp++; if ({inst_valid, inst_tag, inst_index, inst_offset, inst_cache, inst_refill, inst_invalid} !== {1'b1, 20'h1FC01, 8'h23, 4'h4, 1'b1, 1'b0, 1'b0})
      begin n_err++; $display("FAIL kseg0 got v=%0b tag=%h idx=%h off=%h c=%0b", inst_valid, inst_tag, inst_index, inst_offset, inst_cache); end
    cyc();
    inst_req = 1'b0;
    n_cmp++; if ({inst_valid, inst_tag, inst_index, inst_offset, inst_cache, inst_refill} !== {1'b1, 20'h1FC00, 8'h00, 4'h0, 1'b0, 1'b0})
      begin n_err++; $display("FAIL kseg1 got v=%0b tag=%h idx=%h off=%h c=%0b", inst_valid, inst_tag, inst_index, inst_offset, inst_cache); end
    cyc();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %0b want 0", inst_valid); end
  endtask

  task automatic test_refill_empty();
    data_req = 1'b1; data_vaddr = 32'h0040_0000;
    cyc();
    data_req = 1'b0;
    n_cmp++; if ({data_valid, data_refill, data_invalid, data_tag, data_index, data_offset, data_cache} !== {1'b1, 1'b1, 1'b0, 33'd0})
      begin n_err++; $display("FAIL empty_refill got v=%0b r=%0b tag=%h", data_valid, data_refill, data_tag); end
  endtask

  task automatic test_mapped();
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, LO_A, LO_INV);
    asid = 8'd5; data_req = 1'b1; data_vaddr = 32'h0040_0ABC;
    cyc();
    data_vaddr = 32'h0040_1000;
    n_cmp++; if ({data_valid, data_tag, data_index, data_offset, data_cache, data_refill, data_invalid} !== {1'b1, 20'h12345, 8'hAB, 4'hC, 1'b1, 1'b0, 1'b0})
      begin n_err++; $display("FAIL mapped got tag=%h idx=%h off=%h c=%0b r=%0b", data_tag, data_index, data_offset, data_cache, data_refill); end
    cyc();
    data_vaddr = 32'h0040_0ABC; asid = 8'd6;
    n_cmp++; if ({data_invalid, data_refill, data_tag} !== {1'b1, 1'b0, 20'h0})
      begin n_err++; $display("FAIL odd_invalid got inv=%0b r=%0b tag=%h", data_invalid, data_refill, data_tag); end
    cyc();
    data_req = 1'b0; asid = 8'd5;
    n_cmp++; if ({data_refill, data_invalid, data_tag} !== {1'b1, 1'b0, 20'h0})
      begin n_err++; $display("FAIL asid_refill got r=%0b inv=%0b tag=%h", data_refill, data_invalid, data_tag); end
  endtask

  task automatic test_mod();
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, LO_A_ND, LO_INV);
    data_req = 1'b1; data_wr = 1'b1; data_vaddr = 32'h0040_0ABC;
    cyc();
    data_wr = 1'b0;
    n_cmp++; if ({data_mod, data_refill, data_invalid, data_tag, data_cache} !== {1'b1, 1'b0, 1'b0, 21'd0})
      begin n_err++; $display("FAIL store_mod got mod=%0b tag=%h", data_mod, data_tag); end
    cyc();
    data_req = 1'b0;
    n_cmp++; if ({data_mod, data_tag, data_index, data_offset} !== {1'b0, 20'h12345, 8'hAB, 4'hC})
      begin n_err++; $display("FAIL load_nomod got mod=%0b tag=%h", data_mod, data_tag); end
  endtask

  task automatic test_probe();
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h00200;
    cyc();
    tlbp_req = 1'b0;
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== {1'b1, 1'b1, 3'd3})
      begin n_err++; $display("FAIL probe_hit got d=%0b h=%0b i=%0d want 1 1 3", tlbp_done, tlbp_hit, tlbp_idx); end
    cyc();
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== {1'b0, 1'b1, 3'd3})
      begin n_err++; $display("FAIL probe_hold got d=%0b h=%0b i=%0d want 0 1 3", tlbp_done, tlbp_hit, tlbp_idx); end
    tlbp_req = 1'b1;
    tlbw(3'd3, 19'h00300, 8'd5, 1'b0, LO_A, LO_A);
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== {1'b1, 1'b1, 3'd3})
      begin n_err++; $display("FAIL probe_old got d=%0b h=%0b i=%0d want 1 1 3", tlbp_done, tlbp_hit, tlbp_idx); end
    cyc();
    tlbp_req = 1'b0;
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== {1'b1, 1'b0, 3'd0})
      begin n_err++; $display("FAIL probe_new got d=%0b h=%0b i=%0d want 1 0 0", tlbp_done, tlbp_hit, tlbp_idx); end
    tlbw(3'd1, 19'h00300, 8'd5, 1'b0, LO_A, LO_A);
    tlbp_req = 1'b1; tlbp_vpn2 = 19'h00300;
    cyc();
    tlbp_req = 1'b0;
    n_cmp++; if ({tlbp_done, tlbp_hit, tlbp_idx} !== {1'b1, 1'b1, 3'd1})
      begin n_err++; $display("FAIL probe_dup got d=%0b h=%0b i=%0d want 1 1 1", tlbp_done, tlbp_hit, tlbp_idx); end
  endtask

  task automatic test_back_to_back();
    tlbw(3'd0, 19'h00100, 8'd9, 1'b1, {20'h0ABCD, 3'd2, 1'b1, 1'b1}, {20'h0ABCE, 3'd3, 1'b1, 1'b1});
    asid = 8'h77;
    inst_req = 1'b1; inst_vaddr = 32'h8000_0040;
    data_req = 1'b1; data_vaddr = 32'h0020_0010;
    cyc();
    inst_vaddr = 32'hA000_1230; data_vaddr = 32'h0020_1FFF;
    n_cmp++; if ({inst_valid, inst_tag, inst_index, inst_offset, inst_cache} !== {1'b1, 20'h0, 8'h04, 4'h0, 1'b1})
      begin n_err++; $display("FAIL b2b_i0 got tag=%h idx=%h c=%0b", inst_tag, inst_index, inst_cache); end
    n_cmp++; if ({data_valid, data_tag, data_index, data_offset, data_cache, data_refill} !== {1'b1, 20'h0ABCD, 8'h01, 4'h0, 1'b0, 1'b0})
      begin n_err++; $display("FAIL b2b_d0 got tag=%h idx=%h c=%0b r=%0b", data_tag, data_index, data_cache, data_refill); end
    cyc();
    inst_req = 1'b0; data_req = 1'b0;
    n_cmp++; if ({inst_valid, inst_tag, inst_index, inst_offset, inst_cache} !== {1'b1, 20'h00001, 8'h23, 4'h0, 1'b0})
      begin n_err++; $display("FAIL b2b_i1 got tag=%h idx=%h c=%0b", inst_tag, inst_index, inst_cache); end
    n_cmp++; if ({data_valid, data_tag, data_index, data_offset, data_cache} !== {1'b1, 20'h0ABCE, 8'hFF, 4'hF, 1'b1})
      begin n_err++; $display("FAIL b2b_d1 got tag=%h idx=%h off=%h c=%0b", data_tag, data_index, data_offset, data_cache); end
    cyc();
    n_cmp++; if ({inst_valid, data_valid} !== 2'b00)
      begin n_err++; $display("FAIL b2b_gap got %b want 00", {inst_valid, data_valid}); end
  endtask

  task automatic test_rst_drop();
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, LO_A, LO_A);
    asid = 8'd5;
    rst = 1'b1; data_req = 1'b1; inst_req = 1'b1; tlbp_req = 1'b1;
    data_vaddr = 32'h0040_0ABC; inst_vaddr = 32'h8000_0000; tlbp_vpn2 = 19'h00200;
    cyc();
    rst = 1'b0; inst_req = 1'b0; tlbp_req = 1'b0;
    n_cmp++; if ({inst_valid, data_valid, tlbp_done} !== 3'b000)
      begin n_err++; $display("FAIL rst_drop got %b want 000", {inst_valid, data_valid, tlbp_done}); end
    cyc();
    data_req = 1'b0;
    n_cmp++; if ({data_valid, data_refill, data_tag} !== {1'b1, 1'b1, 20'h0})
      begin n_err++; $display("FAIL rst_cleared got v=%0b r=%0b tag=%h", data_valid, data_refill, data_tag); end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_refill_empty();
    test_mapped();
    test_mod();
    test_probe();
    test_back_to_back();
    test_rst_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
